// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin req/gnt arbiter with registered one-hot grant, hold timeout and revoke blocking.
// Define RR_ARB_ASSERT_EN to elaborate the embedded SVA checkers.
module rr_req_gnt_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned CNT_W   = $clog2(MAX_HOLD + 1),
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout,
  output logic [NUM_REQ-1:0] blocked
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               timeout_q, timeout_d;
  logic [NUM_REQ-1:0] blocked_q, blocked_d;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;

  // (base + off) mod NUM_REQ, valid for any NUM_REQ, not just powers of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= (ID_W + 1)'(NUM_REQ)) begin
      sum = sum - (ID_W + 1)'(NUM_REQ);
    end
    return sum[ID_W-1:0];
  endfunction

  assign eligible = req & ~blocked_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [ID_W-1:0] cand;
      cand = wrap_add(ptr_q, (ID_W + 1)'(k));
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    // A channel is unblocked on any edge where its request is seen low.
    blocked_d = blocked_q & req;

    case (state_q)
      // The single gap cycle also arbitrates at its exit edge, so grants are
      // separated by exactly one gnt=0 cycle when requests are pending.
      StIdle, StGap: begin
        if (pick_found) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gnt_id_d        = pick_idx;
          hold_d          = CNT_W'(1);
          state_d         = StGrant;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        if (!req[gnt_id_q]) begin
          gnt_d   = '0;
          ptr_d   = wrap_add(gnt_id_q, (ID_W + 1)'(1));
          hold_d  = '0;
          state_d = StGap;
        end else if (hold_q == CNT_W'(MAX_HOLD)) begin
          gnt_d               = '0;
          ptr_d               = wrap_add(gnt_id_q, (ID_W + 1)'(1));
          hold_d              = '0;
          timeout_d           = 1'b1;
          blocked_d[gnt_id_q] = 1'b1;
          state_d             = StGap;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      blocked_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      blocked_q <= blocked_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;
  assign blocked = blocked_q;

`ifdef RR_ARB_ASSERT_EN
  localparam int unsigned FairBound = NUM_REQ * (MAX_HOLD + 2);

  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt))
    else $error("rr_req_gnt_arbiter: gnt not onehot0, gnt=%b", gnt);

  a_timeout_fall: assert property (@(posedge clk) disable iff (reset) timeout |-> $fell(busy))
    else $error("rr_req_gnt_arbiter: timeout without gnt fall, channel %0d", gnt_id);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
    int unsigned wait_q;
    int unsigned run_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wait_q <= 0;
        run_q  <= 0;
      end else begin
        wait_q <= (gnt[i] || !req[i] || blocked[i]) ? 0 : wait_q + 1;
        run_q  <= gnt[i] ? run_q + 1 : 0;
      end
    end

    a_fair: assert property (@(posedge clk) disable iff (reset) wait_q < FairBound)
      else $error("rr_req_gnt_arbiter: channel %0d starved", i);

    a_hold: assert property (@(posedge clk) disable iff (reset) run_q <= MAX_HOLD)
      else $error("rr_req_gnt_arbiter: channel %0d held gnt too long", i);
  end
`endif

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Directed bench for rr_req_gnt_arbiter (NUM_REQ=4, MAX_HOLD=8) with an expected-output queue.
module tb_rr_req_gnt_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic [3:0] blocked;

  typedef struct packed {
    logic [3:0] gnt;
    logic       to;
    logic [3:0] blk;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  rr_req_gnt_arbiter #(
    .NUM_REQ (4),
    .MAX_HOLD(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .timeout(timeout),
    .blocked(blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = 2'(i);
    end
    return r;
  endfunction

  task automatic push_exp(input logic [3:0] eg, input logic et, input logic [3:0] eb);
    exp_t e;
    e.gnt = eg;
    e.to  = et;
    e.blk = eb;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    step++;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard step %0d: observed empty queue, expected an entry", step);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    assert (gnt === e.gnt) else begin
      errors++;
      $error("FAIL gnt step %0d: observed %b expected %b", step, gnt, e.gnt);
    end
    checks++;
    assert (busy === (|e.gnt)) else begin
      errors++;
      $error("FAIL busy step %0d: observed %b expected %b", step, busy, |e.gnt);
    end
    checks++;
    assert (timeout === e.to) else begin
      errors++;
      $error("FAIL timeout step %0d: observed %b expected %b", step, timeout, e.to);
    end
    checks++;
    assert (blocked === e.blk) else begin
      errors++;
      $error("FAIL blocked step %0d: observed %b expected %b", step, blocked, e.blk);
    end
    if (|e.gnt) begin
      checks++;
      assert (gnt_id === idx_of(e.gnt)) else begin
        errors++;
        $error("FAIL gnt_id step %0d: observed %0d expected %0d", step, gnt_id, idx_of(e.gnt));
      end
    end
  endtask

  // Drive req mid-cycle; expectation applies to the outputs after the next edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] eg, input logic et,
                     input logic [3:0] eb);
    req = r;
    push_exp(eg, et, eb);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    #20;
    push_exp(4'b0000, 1'b0, 4'b0000);
    check_out();
    checks++;
    assert (gnt_id === 2'd0) else begin
      errors++;
      $error("FAIL reset_gnt_id: observed %0d expected 0", gnt_id);
    end
    reset = 1'b0;

    // Single requester, 3-cycle grant, then one gap cycle.
    repeat (3) cyc(4'b0010, 4'b0010, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);
    // Pointer now 2: among {0,1,3} channel 3 wins.
    cyc(4'b1011, 4'b1000, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);

    // All request; each owner holds 2 cycles, drops, re-asserts.
    for (int o = 0; o < 4; o++) begin
      logic [3:0] oh;
      oh = 4'b0001 << o;
      if (o == 0) cyc(4'b1111, oh, 1'b0, 4'b0000);
      else        cyc(4'b1111, oh, 1'b0, 4'b0000);
      cyc(4'b1111, oh, 1'b0, 4'b0000);
      cyc(4'b1111 & ~oh, 4'b0000, 1'b0, 4'b0000);
    end
    cyc(4'b1111, 4'b0001, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);

    // Hold timeout: 8 grant cycles, revoke with pulse, blocked until req drops.
    repeat (8) cyc(4'b0100, 4'b0100, 1'b0, 4'b0000);
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0100);
    repeat (3) cyc(4'b0100, 4'b0000, 1'b0, 4'b0100);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);
    cyc(4'b0100, 4'b0100, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);

    // Owner releases on the same edge the hold count reaches the limit.
    repeat (8) cyc(4'b0001, 4'b0001, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);

    // Timeout on channel 1, channel 2 granted, then async reset mid-grant.
    repeat (8) cyc(4'b0010, 4'b0010, 1'b0, 4'b0000);
    cyc(4'b0110, 4'b0000, 1'b1, 4'b0010);
    cyc(4'b0110, 4'b0100, 1'b0, 4'b0010);
    cyc(4'b0110, 4'b0100, 1'b0, 4'b0010);
    #3;
    reset = 1'b1;
    push_exp(4'b0000, 1'b0, 4'b0000);
    #1;
    check_out();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(4'b0110, 4'b0010, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000);

`ifdef RR_ARB_ASSERT_EN
    // Two-hot grant should trip the embedded onehot0 checker.
    force dut.gnt = 4'b0011;
    @(posedge clk);
    #1;
    release dut.gnt;
    @(posedge clk);
    #1;
`endif

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
